// File: rtl/mac_seq.sv
// mac_seq: sequences one dot product through a pipelined MAC per start and returns the result on a valid/ready port
module mac_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 8,
  parameter int CNT_W      = $clog2(VEC_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  input  logic                    op_valid,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic                    op_ready,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [DATA_WIDTH-1:0]   mac_ain,
  output logic [DATA_WIDTH-1:0]   mac_bin,
  input  logic [3*DATA_WIDTH-1:0] mac_cout,
  output logic                    res_valid,
  output logic [3*DATA_WIDTH-1:0] res_data,
  input  logic                    res_ready,
  output logic                    done
);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, HOLD} state_t;
  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [1:0]              drn_q;
  logic [DATA_WIDTH-1:0]   ain_q, bin_q;
  logic [3*DATA_WIDTH-1:0] res_q;
  logic                    hs;
  assign busy      = state_q != IDLE;
  assign op_ready  = state_q == FEED && cnt_q < CNT_W'(VEC_LEN);
  assign hs        = op_valid & op_ready;
  assign mac_en    = hs;
  assign mac_clr   = state_q == CLEAR;
  assign mac_ain   = ain_q;
  assign mac_bin   = bin_q;
  assign res_valid = state_q == HOLD;
  assign res_data  = res_q;
  assign done      = res_valid & res_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drn_q   <= '0;
      ain_q   <= '0;
      bin_q   <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= CLEAR;
          cnt_q   <= '0;
        end
        CLEAR: state_q <= FEED;
        FEED: if (hs) begin
          ain_q <= op_a;
          bin_q <= op_b;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(VEC_LEN - 1)) begin
            state_q <= DRAIN;
            drn_q   <= '0;
          end
        end
        // last element reaches Cout on the third drain cycle
        DRAIN: begin
          drn_q <= drn_q + 1'b1;
          if (drn_q == 2'd2) begin
            res_q   <= mac_cout;
            state_q <= HOLD;
          end
        end
        HOLD: if (res_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: directed checks of mac_seq driving a behavioural pipelined MAC
module tb_mac_seq;
  logic        clk = 0;
  logic        rst, start, op_valid, res_ready;
  logic [7:0]  op_a, op_b;
  logic        busy, op_ready, mac_en, mac_clr, res_valid, done;
  logic [7:0]  mac_ain, mac_bin;
  logic [23:0] mac_cout, res_data;
  int          tests = 0, fails = 0, cyc = 0, last_hs = 0;

  mac_seq dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_ain(mac_ain), .mac_bin(mac_bin),
    .mac_cout(mac_cout), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .done(done)
  );

  always #5 clk = ~clk;

  // MAC: En/Clr at t, operands at t+1, product at t+2, Cout from t+3
  logic        en1, clr1, en2, clr2;
  logic [15:0] prod;
  always @(posedge clk) begin
    if (rst) begin
      {en1, clr1, en2, clr2} <= '0;
      prod     <= '0;
      mac_cout <= '0;
    end else begin
      en1  <= mac_en;
      clr1 <= mac_clr;
      en2  <= en1;
      clr2 <= clr1;
      prod <= mac_ain * mac_bin;
      mac_cout <= clr2 ? 24'd0 : en2 ? mac_cout + {8'd0, prod} : mac_cout;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (!rst) check("clr_en_excl", {31'd0, mac_clr & mac_en}, 32'd0);

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic begin_run();
    start = 1;
    tick();
    start = 0;
    check("clear_clr", {31'd0, mac_clr}, 1);
    check("clear_busy", {31'd0, busy}, 1);
    check("clear_ready", {31'd0, op_ready}, 0);
    tick();
  endtask

  task automatic feed(input int n, input logic [7:0] a0, input logic [7:0] ainc,
                      input logic [7:0] b, input bit gap);
    logic [7:0] a;
    a = a0;
    for (int i = 0; i < n; i++) begin
      op_valid = 1; op_a = a; op_b = b;
      #1;
      check("feed_ready", {31'd0, op_ready}, 1);
      check("feed_en", {31'd0, mac_en}, 1);
      last_hs = cyc;
      tick();
      op_valid = 0;
      check("ain_reg", {24'd0, mac_ain}, {24'd0, a});
      check("bin_reg", {24'd0, mac_bin}, {24'd0, b});
      if (gap && i != n - 1) begin
        #1;
        check("bubble_en", {31'd0, mac_en}, 0);
        tick();
      end
      a = a + ainc;
    end
  endtask

  task automatic wait_res(input logic [23:0] exp);
    int n;
    n = 1;
    check("drain_ready", {31'd0, op_ready}, 0);
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    check("res_valid", {31'd0, res_valid}, 1);
    check("res_latency", n, 4);
    check("res_data", {8'd0, res_data}, {8'd0, exp});
  endtask

  task automatic take_res();
    res_ready = 1;
    #1;
    check("done_pulse", {31'd0, done}, 1);
    tick();
    res_ready = 0;
    check("after_valid", {31'd0, res_valid}, 0);
    check("after_done", {31'd0, done}, 0);
    check("after_busy", {31'd0, busy}, 0);
  endtask

  initial begin
    rst = 1; start = 0; op_valid = 0; res_ready = 0; op_a = 0; op_b = 0;
    tick(); tick();
    rst = 0;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ready", {31'd0, op_ready}, 0);
    check("rst_valid", {31'd0, res_valid}, 0);
    check("rst_data", {8'd0, res_data}, 0);
    check("rst_ain", {24'd0, mac_ain}, 0);
    check("rst_clr", {31'd0, mac_clr}, 0);
    tick();
    check("idle_busy", {31'd0, busy}, 0);
    // 1: A=1..8, B=1
    begin_run(); feed(8, 8'd1, 8'd1, 8'd1, 0); wait_res(24'd36); take_res();
    // 2: all 255
    begin_run(); feed(8, 8'd255, 8'd0, 8'd255, 0); wait_res(24'd520200); take_res();
    // 3 and 4: bubbles, then a stalled result
    begin_run(); feed(8, 8'd2, 8'd0, 8'd3, 1); wait_res(24'd48);
    start = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", {31'd0, res_valid}, 1);
      check("hold_data", {8'd0, res_data}, 32'd48);
      check("hold_ready", {31'd0, op_ready}, 0);
      check("hold_done", {31'd0, done}, 0);
      check("hold_clr", {31'd0, mac_clr}, 0);
    end
    start = 0;
    take_res();
    check("no_queue_clr", {31'd0, mac_clr}, 0);
    // 5: back-to-back
    begin_run(); feed(8, 8'd1, 8'd0, 8'd1, 0); wait_res(24'd8); take_res();
    begin_run(); feed(8, 8'd2, 8'd0, 8'd2, 0); wait_res(24'd32); take_res();
    // 6: abort after 4 handshakes
    begin_run(); feed(4, 8'd1, 8'd1, 8'd1, 0);
    rst = 1;
    tick();
    rst = 0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_ready", {31'd0, op_ready}, 0);
    check("abort_valid", {31'd0, res_valid}, 0);
    check("abort_ain", {24'd0, mac_ain}, 0);
    check("abort_en", {31'd0, mac_en}, 0);
    check("abort_data", {8'd0, res_data}, 0);
    tick();
    begin_run(); feed(8, 8'd1, 8'd1, 8'd1, 0); wait_res(24'd36); take_res();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
